// File: rtl/prog_freq_div_if.sv
// Control/status bundle for prog_freq_div: run request, config load, divided outputs.
// PROG_FREQ_DIV_SYNC_EN adds the phase_sync request line.
interface prog_freq_div_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             cfg_load;
    logic [CNT_W-1:0] div_val;
    logic [CNT_W-1:0] high_val;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic             cfg_err;
`ifdef PROG_FREQ_DIV_SYNC_EN
    logic             phase_sync;

    modport master (
        output en, cfg_load, div_val, high_val, phase_sync,
        input  clk_out, tick, running, cfg_err
    );
    modport slave (
        input  en, cfg_load, div_val, high_val, phase_sync,
        output clk_out, tick, running, cfg_err
    );
`else
    modport master (
        output en, cfg_load, div_val, high_val,
        input  clk_out, tick, running, cfg_err
    );
    modport slave (
        input  en, cfg_load, div_val, high_val,
        output clk_out, tick, running, cfg_err
    );
`endif
endinterface

// File: rtl/prog_freq_div.sv
// Runtime-programmable divided clock / period tick with shadowed divide and high-time.
// Define PROG_FREQ_DIV_SYNC_EN to add the phase_sync input (counter realignment).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stopped, cnt held at 0, outputs low, config applies at once
// RUN      | counting periods, en held high
// STOPPING | en dropped, finishing the current period before IDLE
module prog_freq_div #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 100,
    parameter int DEFAULT_HIGH = 50
) (
    input  logic           clk,
    input  logic           reset,
    prog_freq_div_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_act, div_n;
    logic [CNT_W-1:0] high_act, high_n;
    logic [CNT_W-1:0] div_shd, div_shd_n;
    logic [CNT_W-1:0] high_shd, high_shd_n;
    logic             pend, pend_n;
    logic             clk_out_q, tick_q, running_q, cfg_err_q;
    logic             wrap, sync_req, load_ok, boundary, live_n;
    logic [CNT_W-1:0] high_clamp;

`ifdef PROG_FREQ_DIV_SYNC_EN
    assign sync_req = bus.phase_sync;
`else
    assign sync_req = 1'b0;
`endif

    assign wrap       = (cnt == div_act - CNT_W'(1));
    assign load_ok    = bus.cfg_load && (bus.div_val != '0);
    // High time is clamped against the divisor of the same load, so cnt < high_act is always well defined.
    assign high_clamp = (bus.high_val > bus.div_val) ? bus.div_val : bus.high_val;
    assign live_n     = (state_n != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_act  <= CNT_W'(DEFAULT_DIV);
            high_act <= CNT_W'(DEFAULT_HIGH);
            div_shd  <= CNT_W'(DEFAULT_DIV);
            high_shd <= CNT_W'(DEFAULT_HIGH);
            pend     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div_act  <= div_n;
            high_act <= high_n;
            div_shd  <= div_shd_n;
            high_shd <= high_shd_n;
            pend     <= pend_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div_act;
        high_n     = high_act;
        div_shd_n  = div_shd;
        high_shd_n = high_shd;
        pend_n     = pend;
        boundary   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n    = '0;
                boundary = 1'b1;
                if (bus.en) state_n = RUN;
            end
            RUN: begin
                cnt_n    = (wrap || sync_req) ? '0 : cnt + CNT_W'(1);
                boundary = wrap || sync_req;
                if (!bus.en) state_n = STOPPING;
            end
            STOPPING: begin
                cnt_n    = (wrap || sync_req) ? '0 : cnt + CNT_W'(1);
                boundary = wrap || sync_req;
                if (bus.en)    state_n = RUN;
                else if (wrap) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Pending values take effect first, so a load on the boundary cycle waits for the next one.
        if (boundary && pend) begin
            div_n  = div_shd;
            high_n = high_shd;
            pend_n = 1'b0;
        end

        if (load_ok) begin
            div_shd_n  = bus.div_val;
            high_shd_n = high_clamp;
            if (state == IDLE) begin
                div_n  = bus.div_val;
                high_n = high_clamp;
                pend_n = 1'b0;
            end else begin
                pend_n = 1'b1;
            end
        end
    end

    // Outputs are registered from the next-state values so they line up with the cnt register.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            clk_out_q <= live_n && (cnt_n < high_n);
            tick_q    <= live_n && (cnt_n == '0);
            running_q <= live_n;
            cfg_err_q <= bus.cfg_load && (bus.div_val == '0);
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.running = running_q;
    assign bus.cfg_err = cfg_err_q;
endmodule
